// File: rtl/collision_pkg.sv
// Shared types and elaboration helpers for the collision engine.
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BALL,
        ST_PIN,
        ST_DRAIN
    } state_e;

    // Squared-distance width: one extra bit for the signed difference,
    // doubled for the square, plus one carry bit for the sum of two squares.
    function automatic int dist_w(input int xw, input int yw);
        return 2 * (((xw > yw) ? xw : yw) + 1) + 1;
    endfunction

    function automatic int pair_count(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value into the range of a width-bit two's-complement number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/collision_dist_sq.sv
// Pipeline stage 1: signed coordinate differences squared and summed, registered.
module collision_dist_sq #(
    parameter int CW     = 11,
    parameter int DIST_W = 25
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [CW-1:0]     ax_i,
    input  logic [CW-1:0]     ay_i,
    input  logic [CW-1:0]     bx_i,
    input  logic [CW-1:0]     by_i,
    output logic              valid_o,
    output logic [DIST_W-1:0] dsq_o
);

    logic signed [CW:0]       dx;
    logic signed [CW:0]       dy;
    logic signed [DIST_W-1:0] dxWide;
    logic signed [DIST_W-1:0] dyWide;
    logic signed [DIST_W-1:0] sumSq;
    logic                     valid_q;
    logic [DIST_W-1:0]        dsq_q;

    // Differences are sign-extended to the full distance width before squaring so nothing is truncated.
    always_comb begin
        dx     = $signed({1'b0, ax_i}) - $signed({1'b0, bx_i});
        dy     = $signed({1'b0, ay_i}) - $signed({1'b0, by_i});
        dxWide = {{(DIST_W - CW - 1){dx[CW]}}, dx};
        dyWide = {{(DIST_W - CW - 1){dy[CW]}}, dy};
        sumSq  = dxWide * dxWide + dyWide * dyWide;
    end

    // Register the squared distance together with its valid flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            dsq_q   <= '0;
        end else begin
            valid_q <= valid_i;
            dsq_q   <= $unsigned(sumSq);
        end
    end

    assign valid_o = valid_q;
    assign dsq_o   = dsq_q;

endmodule

// File: rtl/collision_engine.sv
// Time-multiplexed ball/pin and pin/pin collision resolver. One pair per cycle
// flows through a two-stage squared-distance pipeline; velocity updates chain
// so later pairs see the results of earlier ones.
module collision_engine
    import collision_pkg::*;
#(
    parameter int NUM_PINS      = 10,
    parameter int X_W           = 11,
    parameter int Y_W           = 10,
    parameter int VEL_W         = 16,
    parameter int BALL_RADIUS   = 166,
    parameter int PIN_RADIUS    = 90,
    parameter int BALL_MASS     = 3,
    parameter int PIN_MASS      = 1,
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic                      pin_pin_en_in,
    input  logic [X_W-1:0]            ball_x_in,
    input  logic [Y_W-1:0]            ball_y_in,
    input  logic [VEL_W-1:0]          ball_vx_in,
    input  logic [VEL_W-1:0]          ball_vy_in,
    input  logic [NUM_PINS*X_W-1:0]   pins_x_in,
    input  logic [NUM_PINS*Y_W-1:0]   pins_y_in,
    input  logic [NUM_PINS*VEL_W-1:0] pins_vx_in,
    input  logic [NUM_PINS*VEL_W-1:0] pins_vy_in,
    output logic [NUM_PINS*VEL_W-1:0] pins_vx_out,
    output logic [NUM_PINS*VEL_W-1:0] pins_vy_out,
    output logic [NUM_PINS-1:0]       pins_hit_out,
    output logic                      done_out
);

    localparam int CW         = (X_W > Y_W) ? X_W : Y_W;
    localparam int DIST_W     = dist_w(X_W, Y_W);
    localparam int IW         = idx_w(NUM_PINS);
    localparam int VW         = VEL_W + 8;
    localparam int MASS_SHIFT = $clog2(BALL_MASS + PIN_MASS);

    localparam logic [DIST_W-1:0]     BP_LIMIT  = DIST_W'((BALL_RADIUS + PIN_RADIUS) * (BALL_RADIUS + PIN_RADIUS));
    localparam logic [DIST_W-1:0]     PP_LIMIT  = DIST_W'((2 * PIN_RADIUS) * (2 * PIN_RADIUS));
    localparam logic signed [VW-1:0]  BALL_COEF = VW'(2 * BALL_MASS);
    localparam logic signed [VW-1:0]  PIN_COEF  = VW'(BALL_MASS - PIN_MASS);
    localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_PINS - 1);
    localparam logic [IW-1:0]         PEN_IDX   = IW'(NUM_PINS - 2);
    localparam logic [IW-1:0]         ONE       = IW'(1);
    localparam logic [IW-1:0]         TWO       = IW'(2);

    // The shift-based divide needs a power-of-two mass sum; the saturator works on 32-bit values.
    if (((BALL_MASS + PIN_MASS) & (BALL_MASS + PIN_MASS - 1)) != 0) begin : g_mass_check
        $error("collision_engine: BALL_MASS + PIN_MASS must be a power of two");
    end
    if (NUM_PINS < 2 || VEL_W > 24) begin : g_size_check
        $error("collision_engine: NUM_PINS must be >= 2 and VEL_W <= 24");
    end

    state_e                  state_q;
    logic                    ready_q;
    logic                    done_q;
    logic                    pinPinEn_q;
    logic [IW-1:0]           idxA_q;
    logic [IW-1:0]           idxB_q;
    logic [X_W-1:0]          ballX_q;
    logic [Y_W-1:0]          ballY_q;
    logic signed [VEL_W-1:0] ballVx_q;
    logic signed [VEL_W-1:0] ballVy_q;
    logic [X_W-1:0]          pinX_q  [NUM_PINS];
    logic [Y_W-1:0]          pinY_q  [NUM_PINS];
    logic signed [VEL_W-1:0] vx_q    [NUM_PINS];
    logic signed [VEL_W-1:0] vy_q    [NUM_PINS];
    logic signed [VEL_W-1:0] vx_d    [NUM_PINS];
    logic signed [VEL_W-1:0] vy_d    [NUM_PINS];
    logic [NUM_PINS-1:0]     hit_q;
    logic [NUM_PINS-1:0]     hit_d;
    logic [NUM_PINS-1:0]     offPlay;
    logic                    s1Ball_q;
    logic                    s1Skip_q;
    logic                    s1Last_q;
    logic [IW-1:0]           s1A_q;
    logic [IW-1:0]           s1B_q;
    logic [NUM_PINS*VEL_W-1:0] vxOut_q;
    logic [NUM_PINS*VEL_W-1:0] vyOut_q;
    logic [NUM_PINS-1:0]       hitOut_q;

    logic                    accept;
    logic                    issueValid;
    logic                    issueBall;
    logic                    issueSkip;
    logic                    issueLast;
    logic [CW-1:0]           issueAx;
    logic [CW-1:0]           issueAy;
    logic [CW-1:0]           issueBx;
    logic [CW-1:0]           issueBy;
    logic                    s1Valid;
    logic [DIST_W-1:0]       s1Dsq;
    logic                    bpHit;
    logic                    ppHit;

    // Momentum exchange of the heavier ball onto one pin axis, floor-divided by the mass sum and clamped.
    function automatic logic signed [VEL_W-1:0] ballHitVel(input logic signed [VEL_W-1:0] vb,
                                                           input logic signed [VEL_W-1:0] vk);
        logic signed [VW-1:0] vbWide;
        logic signed [VW-1:0] vkWide;
        logic signed [VW-1:0] mix;
        logic signed [VW-1:0] shifted;
        logic signed [31:0]   clamped;
        vbWide  = {{8{vb[VEL_W-1]}}, vb};
        vkWide  = {{8{vk[VEL_W-1]}}, vk};
        mix     = BALL_COEF * vbWide - PIN_COEF * vkWide;
        shifted = mix >>> MASS_SHIFT;
        clamped = saturate({{(32 - VW){shifted[VW-1]}}, shifted}, VEL_W);
        return clamped[VEL_W-1:0];
    endfunction

    assign accept = valid_in && ready_q;

    // A pin that has left the screen takes no further part in any collision.
    always_comb begin
        for (int k = 0; k < NUM_PINS; k++) begin
            offPlay[k] = (int'(pinX_q[k]) >= SCREEN_WIDTH) || (int'(pinY_q[k]) >= SCREEN_HEIGHT);
        end
    end

    // Select the pair issued into stage 1 this cycle from the scan counters.
    always_comb begin
        issueValid = 1'b0;
        issueBall  = 1'b0;
        issueLast  = 1'b0;
        issueAx    = CW'(ballX_q);
        issueAy    = CW'(ballY_q);
        issueBx    = CW'(pinX_q[idxB_q]);
        issueBy    = CW'(pinY_q[idxB_q]);
        issueSkip  = offPlay[idxB_q];
        if (state_q == ST_BALL) begin
            issueValid = 1'b1;
            issueBall  = 1'b1;
            issueLast  = (idxB_q == LAST_IDX) && !pinPinEn_q;
        end else if (state_q == ST_PIN) begin
            issueValid = 1'b1;
            issueAx    = CW'(pinX_q[idxA_q]);
            issueAy    = CW'(pinY_q[idxA_q]);
            issueSkip  = offPlay[idxA_q] || offPlay[idxB_q];
            issueLast  = (idxA_q == PEN_IDX) && (idxB_q == LAST_IDX);
        end
    end

    collision_dist_sq #(
        .CW     (CW),
        .DIST_W (DIST_W)
    ) u_dist (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .valid_i (issueValid),
        .ax_i    (issueAx),
        .ay_i    (issueAy),
        .bx_i    (issueBx),
        .by_i    (issueBy),
        .valid_o (s1Valid),
        .dsq_o   (s1Dsq)
    );

    // Stage 2: compare against the contact radius and read-modify-write the working velocities.
    always_comb begin
        vx_d  = vx_q;
        vy_d  = vy_q;
        hit_d = hit_q;
        bpHit = s1Valid && s1Ball_q && !s1Skip_q && (s1Dsq <= BP_LIMIT);
        ppHit = s1Valid && !s1Ball_q && !s1Skip_q && (s1Dsq <= PP_LIMIT);
        if (accept) begin
            for (int k = 0; k < NUM_PINS; k++) begin
                vx_d[k] = pins_vx_in[k*VEL_W +: VEL_W];
                vy_d[k] = pins_vy_in[k*VEL_W +: VEL_W];
            end
            hit_d = '0;
        end else if (bpHit) begin
            vx_d[s1B_q]  = ballHitVel(ballVx_q, vx_q[s1B_q]);
            vy_d[s1B_q]  = ballHitVel(ballVy_q, vy_q[s1B_q]);
            hit_d[s1B_q] = 1'b1;
        end else if (ppHit) begin
            vx_d[s1A_q]  = vx_q[s1B_q];
            vx_d[s1B_q]  = vx_q[s1A_q];
            vy_d[s1A_q]  = vy_q[s1B_q];
            vy_d[s1B_q]  = vy_q[s1A_q];
            hit_d[s1A_q] = 1'b1;
            hit_d[s1B_q] = 1'b1;
        end
    end

    // Frame sequencer: snapshot, pair scan, pipeline drain, and the registered handshake/result outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            pinPinEn_q <= 1'b0;
            idxA_q     <= '0;
            idxB_q     <= '0;
            ballX_q    <= '0;
            ballY_q    <= '0;
            ballVx_q   <= '0;
            ballVy_q   <= '0;
            hit_q      <= '0;
            s1Ball_q   <= 1'b0;
            s1Skip_q   <= 1'b0;
            s1Last_q   <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            vxOut_q    <= '0;
            vyOut_q    <= '0;
            hitOut_q   <= '0;
            for (int k = 0; k < NUM_PINS; k++) begin
                pinX_q[k] <= '0;
                pinY_q[k] <= '0;
                vx_q[k]   <= '0;
                vy_q[k]   <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            hit_q    <= hit_d;
            s1Ball_q <= issueBall;
            s1Skip_q <= issueSkip;
            s1Last_q <= issueValid && issueLast;
            s1A_q    <= idxA_q;
            s1B_q    <= idxB_q;

            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        state_q    <= ST_BALL;
                        ready_q    <= 1'b0;
                        pinPinEn_q <= pin_pin_en_in;
                        idxB_q     <= '0;
                        ballX_q    <= ball_x_in;
                        ballY_q    <= ball_y_in;
                        ballVx_q   <= ball_vx_in;
                        ballVy_q   <= ball_vy_in;
                        for (int k = 0; k < NUM_PINS; k++) begin
                            pinX_q[k] <= pins_x_in[k*X_W +: X_W];
                            pinY_q[k] <= pins_y_in[k*Y_W +: Y_W];
                        end
                    end
                end
                ST_BALL: begin
                    if (idxB_q == LAST_IDX) begin
                        if (pinPinEn_q) begin
                            state_q <= ST_PIN;
                            idxA_q  <= '0;
                            idxB_q  <= ONE;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        idxB_q <= idxB_q + ONE;
                    end
                end
                ST_PIN: begin
                    if ((idxA_q == PEN_IDX) && (idxB_q == LAST_IDX)) begin
                        state_q <= ST_DRAIN;
                    end else if (idxB_q == LAST_IDX) begin
                        idxA_q <= idxA_q + ONE;
                        idxB_q <= idxA_q + TWO;
                    end else begin
                        idxB_q <= idxB_q + ONE;
                    end
                end
                ST_DRAIN: begin
                    if (!s1Valid) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase

            if (s1Valid && s1Last_q) begin
                done_q   <= 1'b1;
                hitOut_q <= hit_d;
                for (int k = 0; k < NUM_PINS; k++) begin
                    vxOut_q[k*VEL_W +: VEL_W] <= vx_d[k];
                    vyOut_q[k*VEL_W +: VEL_W] <= vy_d[k];
                end
            end
        end
    end

    assign ready_out    = ready_q;
    assign done_out     = done_q;
    assign pins_vx_out  = vxOut_q;
    assign pins_vy_out  = vyOut_q;
    assign pins_hit_out = hitOut_q;

endmodule

// File: tb/tb_collision_engine.sv
// Self-checking bench for collision_engine: directed scenarios plus random
// frames compared against a plain-arithmetic collision model.
module tb_collision_engine;

    localparam int N     = 10;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int VEL_W = 16;
    localparam int BR    = 166;
    localparam int PR    = 90;
    localparam int BM    = 3;
    localparam int PM    = 1;
    localparam int SW    = 1024;
    localparam int SH    = 768;
    localparam int P     = N * (N - 1) / 2;
    localparam int VMAX  = (1 << (VEL_W - 1)) - 1;
    localparam int VMIN  = -(1 << (VEL_W - 1));

    logic                   clk = 1'b0;
    logic                   rstN = 1'b0;
    logic                   validIn = 1'b0;
    logic                   pinPinEn = 1'b0;
    logic [X_W-1:0]         ballX = '0;
    logic [Y_W-1:0]         ballY = '0;
    logic [VEL_W-1:0]       ballVx = '0;
    logic [VEL_W-1:0]       ballVy = '0;
    logic [N*X_W-1:0]       pinsX = '0;
    logic [N*Y_W-1:0]       pinsY = '0;
    logic [N*VEL_W-1:0]     pinsVx = '0;
    logic [N*VEL_W-1:0]     pinsVy = '0;
    logic                   readyOut;
    logic [N*VEL_W-1:0]     pinsVxOut;
    logic [N*VEL_W-1:0]     pinsVyOut;
    logic [N-1:0]           pinsHitOut;
    logic                   doneOut;

    int nAsserts = 0;
    int nFails   = 0;

    int sBallX, sBallY, sBallVx, sBallVy;
    int sPinX[N], sPinY[N], sPinVx[N], sPinVy[N];
    int mVx[N], mVy[N];
    bit mHit[N];

    always #5 clk = ~clk;

    collision_engine #(
        .NUM_PINS(N), .X_W(X_W), .Y_W(Y_W), .VEL_W(VEL_W),
        .BALL_RADIUS(BR), .PIN_RADIUS(PR), .BALL_MASS(BM), .PIN_MASS(PM),
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rstN),
        .valid_in      (validIn),
        .ready_out     (readyOut),
        .pin_pin_en_in (pinPinEn),
        .ball_x_in     (ballX),
        .ball_y_in     (ballY),
        .ball_vx_in    (ballVx),
        .ball_vy_in    (ballVy),
        .pins_x_in     (pinsX),
        .pins_y_in     (pinsY),
        .pins_vx_in    (pinsVx),
        .pins_vy_in    (pinsVy),
        .pins_vx_out   (pinsVxOut),
        .pins_vy_out   (pinsVyOut),
        .pins_hit_out  (pinsHitOut),
        .done_out      (doneOut)
    );

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit inPlay(input int x, input int y);
        return (x < SW) && (y < SH);
    endfunction

    function automatic int distSq(input int ax, input int ay, input int bx, input int by);
        return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
    endfunction

    function automatic int floorDiv(input int a, input int b);
        int q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clampVel(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic int afterBallHit(input int vb, input int vk);
        return clampVel(floorDiv(2 * BM * vb - (BM - PM) * vk, BM + PM));
    endfunction

    // Reference: ball against every pin in order, then every pin pair in order, sequentially.
    task automatic modelFrame(input bit en);
        int t;
        for (int k = 0; k < N; k++) begin
            mVx[k] = sPinVx[k]; mVy[k] = sPinVy[k]; mHit[k] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (inPlay(sPinX[k], sPinY[k]) &&
                distSq(sBallX, sBallY, sPinX[k], sPinY[k]) <= (BR + PR) * (BR + PR)) begin
                mVx[k] = afterBallHit(sBallVx, mVx[k]);
                mVy[k] = afterBallHit(sBallVy, mVy[k]);
                mHit[k] = 1'b1;
            end
        end
        if (en) begin
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j < N; j++) begin
                    if (inPlay(sPinX[i], sPinY[i]) && inPlay(sPinX[j], sPinY[j]) &&
                        distSq(sPinX[i], sPinY[i], sPinX[j], sPinY[j]) <= (2 * PR) * (2 * PR)) begin
                        t = mVx[i]; mVx[i] = mVx[j]; mVx[j] = t;
                        t = mVy[i]; mVy[i] = mVy[j]; mVy[j] = t;
                        mHit[i] = 1'b1; mHit[j] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit en);
        pinPinEn = en;
        ballX  = X_W'(sBallX);
        ballY  = Y_W'(sBallY);
        ballVx = VEL_W'(sBallVx);
        ballVy = VEL_W'(sBallVy);
        for (int k = 0; k < N; k++) begin
            pinsX[k*X_W +: X_W]       = X_W'(sPinX[k]);
            pinsY[k*Y_W +: Y_W]       = Y_W'(sPinY[k]);
            pinsVx[k*VEL_W +: VEL_W]  = VEL_W'(sPinVx[k]);
            pinsVy[k*VEL_W +: VEL_W]  = VEL_W'(sPinVy[k]);
        end
    endtask

    task automatic scrambleInputs();
        pinPinEn = ~pinPinEn;
        ballX    = X_W'($urandom);
        ballY    = Y_W'($urandom);
        ballVx   = VEL_W'($urandom);
        for (int k = 0; k < N; k++) begin
            pinsX[k*X_W +: X_W]      = X_W'($urandom_range(0, 700));
            pinsVx[k*VEL_W +: VEL_W] = VEL_W'($urandom);
        end
    endtask

    // Two well-separated rows of pins, ball parked in a corner: nothing touches.
    task automatic setBase();
        sBallX = 1000; sBallY = 100; sBallVx = 0; sBallVy = 0;
        for (int k = 0; k < N; k++) begin
            sPinX[k]  = (k % 5) * 200;
            sPinY[k]  = (k < 5) ? 560 : 760;
            sPinVx[k] = 0;
            sPinVy[k] = 0;
        end
    endtask

    task automatic checkFrameOutputs(input string tag);
        logic [N*VEL_W-1:0] eVx;
        logic [N*VEL_W-1:0] eVy;
        logic [N-1:0]       eHit;
        for (int k = 0; k < N; k++) begin
            eVx[k*VEL_W +: VEL_W] = VEL_W'(mVx[k]);
            eVy[k*VEL_W +: VEL_W] = VEL_W'(mVy[k]);
            eHit[k]               = mHit[k];
        end
        checkOutput($sformatf("%s vx", tag), pinsVxOut, eVx);
        checkOutput($sformatf("%s vy", tag), pinsVyOut, eVy);
        checkOutput($sformatf("%s hit", tag), pinsHitOut, eHit);
    endtask

    task automatic runFrame(input string tag, input bit en, input bit holdValid);
        int lat;
        int expLat;
        bit readySeen;
        modelFrame(en);
        applyStimulus(en);
        expLat = N + (en ? P : 0) + 1;
        checkOutput($sformatf("%s ready before accept", tag), readyOut, 1'b1);
        validIn = 1'b1;
        @(posedge clk); #1;
        if (holdValid) scrambleInputs();
        else validIn = 1'b0;
        lat = 0;
        readySeen = 1'b0;
        while (doneOut !== 1'b1 && lat < 200) begin
            if (readyOut !== 1'b0) readySeen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (readyOut !== 1'b0) readySeen = 1'b1;
        checkOutput($sformatf("%s done latency", tag), lat, expLat);
        checkOutput($sformatf("%s ready low in frame", tag), readySeen, 1'b0);
        checkFrameOutputs(tag);
        @(posedge clk); #1;
        checkOutput($sformatf("%s done single pulse", tag), doneOut, 1'b0);
        checkOutput($sformatf("%s ready after done", tag), readyOut, 1'b1);
        validIn = 1'b0;
    endtask

    initial begin
        setBase();
        applyStimulus(1'b1);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] checking reset state");
        checkOutput("reset ready", readyOut, 1'b1);
        checkOutput("reset done", doneOut, 1'b0);
        checkOutput("reset vx", pinsVxOut, '0);
        checkOutput("reset vy", pinsVyOut, '0);
        checkOutput("reset hit", pinsHitOut, '0);
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] ball hit");
        setBase();
        sBallX = 500; sBallY = 300; sBallVx = 64;
        sPinX[0] = 600; sPinY[0] = 300;
        runFrame("ball hit", 1'b1, 1'b0);
        checkOutput("ball hit pin0 vx const", pinsVxOut[VEL_W-1:0], 16'd96);
        checkOutput("ball hit flags const", pinsHitOut, 10'b0000000001);

        $display("[TB] pin swap");
        setBase();
        sPinX[1] = 100; sPinY[1] = 100; sPinVx[1] = 5; sPinVy[1] = -3;
        sPinX[2] = 200; sPinY[2] = 100;
        runFrame("pin swap", 1'b1, 1'b0);
        checkOutput("pin swap flags const", pinsHitOut, 10'b0000000110);
        checkOutput("pin swap pin2 vy const", pinsVyOut[2*VEL_W +: VEL_W], 16'hFFFD);
        runFrame("pin swap disabled", 1'b0, 1'b0);
        checkOutput("pin swap disabled flags const", pinsHitOut, 10'b0);

        $display("[TB] off-screen pins");
        setBase();
        sBallX = 1030; sBallY = 100; sBallVx = 100; sBallVy = -50;
        sPinX[3] = 1030; sPinY[3] = 100; sPinVx[3] = 77; sPinVy[3] = -9;
        sPinX[4] = 1030; sPinY[4] = 100; sPinVx[4] = -20;
        runFrame("off screen", 1'b1, 1'b0);

        $display("[TB] saturation");
        setBase();
        sBallX = 500; sBallY = 300; sBallVx = 32767;
        sPinX[0] = 600; sPinY[0] = 300; sPinVx[0] = -32768;
        runFrame("saturation", 1'b1, 1'b0);
        checkOutput("saturation pin0 vx const", pinsVxOut[VEL_W-1:0], 16'h7FFF);

        $display("[TB] handshake with valid held");
        setBase();
        sBallX = 480; sBallY = 320; sBallVx = -200; sBallVy = 150;
        sPinX[0] = 600; sPinY[0] = 300; sPinVx[0] = 40; sPinVy[0] = -7;
        runFrame("handshake", 1'b1, 1'b1);

        $display("[TB] reset mid-frame");
        setBase();
        sBallX = 500; sBallY = 300; sBallVx = 64;
        sPinX[0] = 600; sPinY[0] = 300;
        applyStimulus(1'b1);
        validIn = 1'b1;
        @(posedge clk); #1;
        validIn = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midreset ready", readyOut, 1'b1);
        checkOutput("midreset done", doneOut, 1'b0);
        checkOutput("midreset vx", pinsVxOut, '0);
        checkOutput("midreset vy", pinsVyOut, '0);
        checkOutput("midreset hit", pinsHitOut, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset no done", doneOut, 1'b0);
        rstN = 1'b1;
        @(posedge clk); #1;
        runFrame("after reset", 1'b1, 1'b0);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            sBallX  = $urandom_range(300, 1100);
            sBallY  = $urandom_range(150, 800);
            sBallVx = int'($urandom_range(0, 65535)) - 32768;
            sBallVy = int'($urandom_range(0, 65535)) - 32768;
            for (int k = 0; k < N; k++) begin
                sPinX[k]  = $urandom_range(300, 1100);
                sPinY[k]  = $urandom_range(150, 800);
                sPinVx[k] = int'($urandom_range(0, 65535)) - 32768;
                sPinVy[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            runFrame($sformatf("random %0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
